// File: rtl/median_result_reader.sv
// median_result_reader: captures the median filter's per-pixel write stream into a
// one-bit frame buffer and replays it in raster order (x outer, y inner) with clear-on-read.
module median_result_reader #(
    parameter int X_SIZE = 240,
    parameter int Y_SIZE = 180,
    parameter int ADDR_W = 8
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              writeMedianMem,
    input  logic [ADDR_W-1:0] xAddressOutMedianMem,
    input  logic [ADDR_W-1:0] yAddressOutMedianMem,
    input  logic              writeMedianData,
    input  logic              fullImageDone,
    input  logic              readReady,
    output logic              readValid,
    output logic [ADDR_W-1:0] readX,
    output logic [ADDR_W-1:0] readY,
    output logic              readData,
    output logic              frameDone,
    output logic              busy,
    output logic [15:0]       activeCount,
    output logic              droppedWrite,
    output logic              addrError,
    output logic [1:0]        debugState
);
    localparam int DEPTH = X_SIZE * Y_SIZE;
    localparam int IDX_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam logic [ADDR_W:0]   X_LIM  = (ADDR_W + 1)'(X_SIZE);
    localparam logic [ADDR_W:0]   Y_LIM  = (ADDR_W + 1)'(Y_SIZE);
    localparam logic [ADDR_W-1:0] LAST_X = ADDR_W'(X_SIZE - 1);
    localparam logic [ADDR_W-1:0] LAST_Y = ADDR_W'(Y_SIZE - 1);
    localparam logic [IDX_W-1:0]  LAST_IDX = IDX_W'(DEPTH - 1);

    typedef enum logic [1:0] {
        CLEAR   = 2'd0,
        CAPTURE = 2'd1,
        READ    = 2'd2
    } state_t;

    state_t state, stateNext;

    logic             buffer [DEPTH];
    logic [IDX_W-1:0] clearIdx;
    logic [IDX_W-1:0] writeIdx;
    logic [IDX_W-1:0] readIdx;
    logic [IDX_W-1:0] memAddr;
    logic             memWe;
    logic             memWd;
    logic             fetch;
    logic             inRange;
    logic             captureWrite;
    logic             xfer;
    logic             lastPixel;
    logic             clearLast;

    // Handshake: a pixel moves on any rising edge where readValid && readReady;
    // readX/readY/readData are frozen while readValid is high and readReady is low.
    assign inRange      = ({1'b0, xAddressOutMedianMem} < X_LIM) && ({1'b0, yAddressOutMedianMem} < Y_LIM);
    assign captureWrite = (state == CAPTURE) && writeMedianMem && inRange;
    assign writeIdx     = IDX_W'(xAddressOutMedianMem) * IDX_W'(Y_SIZE) + IDX_W'(yAddressOutMedianMem);
    assign readIdx      = IDX_W'(readX) * IDX_W'(Y_SIZE) + IDX_W'(readY);
    assign xfer         = readValid && readReady;
    assign lastPixel    = (readX == LAST_X) && (readY == LAST_Y);
    assign clearLast    = (clearIdx == LAST_IDX);
    assign busy         = (state != CAPTURE);
    assign debugState   = state;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) state <= CLEAR;
        else        state <= stateNext;
    end

    always_comb begin
        stateNext = state;
        memWe     = 1'b0;
        memAddr   = clearIdx;
        memWd     = 1'b0;
        case (state)
            CLEAR: begin
                memWe = 1'b1;
                if (clearLast) stateNext = CAPTURE;
            end
            CAPTURE: begin
                if (captureWrite) begin
                    memWe   = 1'b1;
                    memAddr = writeIdx;
                    memWd   = writeMedianData;
                end
                if (fullImageDone) stateNext = READ;
            end
            READ: begin
                if (xfer) begin
                    memWe   = 1'b1;
                    memAddr = readIdx;
                    if (lastPixel) stateNext = CAPTURE;
                end
            end
            default: stateNext = CLEAR;
        endcase
    end

    // Frame storage carries no reset; the CLEAR sweep initialises it instead.
    always_ff @(posedge clk) begin
        if (memWe) buffer[memAddr] <= memWd;
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            clearIdx     <= '0;
            fetch        <= 1'b0;
            readValid    <= 1'b0;
            readX        <= '0;
            readY        <= '0;
            readData     <= 1'b0;
            frameDone    <= 1'b0;
            activeCount  <= '0;
            droppedWrite <= 1'b0;
            addrError    <= 1'b0;
        end else begin
            frameDone <= 1'b0;
            if (writeMedianMem && (state != CAPTURE)) droppedWrite <= 1'b1;
            if (writeMedianMem && !inRange)           addrError    <= 1'b1;
            case (state)
                CLEAR: begin
                    if (!clearLast) clearIdx <= clearIdx + 1'b1;
                end
                CAPTURE: begin
                    if (captureWrite && writeMedianData && (activeCount != 16'hFFFF))
                        activeCount <= activeCount + 16'd1;
                    if (fullImageDone) begin
                        readX <= '0;
                        readY <= '0;
                        fetch <= 1'b1;
                    end
                end
                READ: begin
                    if (fetch) begin
                        // One-cycle buffer read; the pixel is presented the following cycle.
                        readData  <= buffer[readIdx];
                        readValid <= 1'b1;
                        fetch     <= 1'b0;
                    end else if (xfer) begin
                        readValid <= 1'b0;
                        if (lastPixel) begin
                            frameDone   <= 1'b1;
                            activeCount <= '0;
                        end else begin
                            fetch <= 1'b1;
                            if (readY == LAST_Y) begin
                                readY <= '0;
                                readX <= readX + 1'b1;
                            end else begin
                                readY <= readY + 1'b1;
                            end
                        end
                    end
                end
                default: ;
            endcase
        end
    end
endmodule

// File: tb/tb_median_result_reader.sv
// Directed-sequence bench for median_result_reader on a reduced 12x10 frame, with a
// per-pixel frame model and an expected readout queue.
module tb_median_result_reader;
    localparam int X_SIZE = 12;
    localparam int Y_SIZE = 10;
    localparam int ADDR_W = 8;
    localparam int DEPTH  = X_SIZE * Y_SIZE;

    typedef struct {
        int x;
        int y;
        bit d;
    } pix_t;

    logic              clk = 1'b0;
    logic              reset = 1'b0;
    logic              writeMedianMem = 1'b0;
    logic [ADDR_W-1:0] xAddressOutMedianMem = '0;
    logic [ADDR_W-1:0] yAddressOutMedianMem = '0;
    logic              writeMedianData = 1'b0;
    logic              fullImageDone = 1'b0;
    logic              readReady = 1'b0;
    logic              readValid;
    logic [ADDR_W-1:0] readX;
    logic [ADDR_W-1:0] readY;
    logic              readData;
    logic              frameDone;
    logic              busy;
    logic [15:0]       activeCount;
    logic              droppedWrite;
    logic              addrError;
    logic [1:0]        debugState;

    int checks = 0;
    int errors = 0;
    bit model [X_SIZE][Y_SIZE];
    int onesWritten = 0;

    median_result_reader #(.X_SIZE(X_SIZE), .Y_SIZE(Y_SIZE), .ADDR_W(ADDR_W)) dut (
        .clk(clk), .reset(reset),
        .writeMedianMem(writeMedianMem),
        .xAddressOutMedianMem(xAddressOutMedianMem),
        .yAddressOutMedianMem(yAddressOutMedianMem),
        .writeMedianData(writeMedianData),
        .fullImageDone(fullImageDone),
        .readReady(readReady),
        .readValid(readValid), .readX(readX), .readY(readY), .readData(readData),
        .frameDone(frameDone), .busy(busy), .activeCount(activeCount),
        .droppedWrite(droppedWrite), .addrError(addrError), .debugState(debugState)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic checkResetValues(input string tag);
        check({tag, "_valid"},   32'(readValid), 0);
        check({tag, "_x"},       32'(readX), 0);
        check({tag, "_y"},       32'(readY), 0);
        check({tag, "_data"},    32'(readData), 0);
        check({tag, "_done"},    32'(frameDone), 0);
        check({tag, "_count"},   32'(activeCount), 0);
        check({tag, "_dropped"}, 32'(droppedWrite), 0);
        check({tag, "_addrerr"}, 32'(addrError), 0);
        check({tag, "_busy"},    32'(busy), 1);
    endtask

    task automatic clearModel();
        for (int x = 0; x < X_SIZE; x++)
            for (int y = 0; y < Y_SIZE; y++)
                model[x][y] = 1'b0;
        onesWritten = 0;
    endtask

    // The sweep must keep busy high for exactly one cycle per pixel after reset release.
    task automatic waitClear();
        int n = 0;
        while (busy && n < 2 * DEPTH) begin
            @(negedge clk);
            n++;
        end
        check("clear_cycles", n, DEPTH);
        check("clear_valid", 32'(readValid), 0);
        check("clear_count", 32'(activeCount), 0);
    endtask

    // Drives one capture-cycle write and applies the capture rules to the model.
    task automatic capture(input int x, input int y, input bit d, input bit done);
        writeMedianMem       = 1'b1;
        xAddressOutMedianMem = ADDR_W'(x);
        yAddressOutMedianMem = ADDR_W'(y);
        writeMedianData      = d;
        fullImageDone        = done;
        if (x < X_SIZE && y < Y_SIZE) begin
            model[x][y] = d;
            if (d) onesWritten++;
        end
        @(negedge clk);
        writeMedianMem  = 1'b0;
        writeMedianData = 1'b0;
        fullImageDone   = 1'b0;
        check("capture_count", 32'(activeCount), 32'(onesWritten));
    endtask

    task automatic pulseDone();
        fullImageDone = 1'b1;
        @(negedge clk);
        fullImageDone = 1'b0;
    endtask

    task automatic writeRandomFrame();
        for (int x = 0; x < X_SIZE; x++)
            for (int y = 0; y < Y_SIZE; y++)
                capture(x, y, bit'($urandom_range(0, 1)), 1'b0);
    endtask

    // Drains one frame against the model. Call right after the fullImageDone cycle.
    task automatic readFrame(input bit randomReady, input int injectAt, input int abortAt);
        pix_t expQ[$];
        pix_t p;
        int   accepted = 0;
        int   cycles = 0;
        int   firstValid = -1;
        bit   accPrev = 0, accPrev2 = 0, stallPrev = 0, accept = 0, injected = 0;
        logic [ADDR_W-1:0] holdX = '0, holdY = '0;
        logic holdD = 1'b0;
        for (int x = 0; x < X_SIZE; x++)
            for (int y = 0; y < Y_SIZE; y++)
                expQ.push_back('{x: x, y: y, d: model[x][y]});
        check("count_before_read", 32'(activeCount), 32'(onesWritten));
        while (expQ.size() > 0 && cycles < 20 * DEPTH) begin
            if (abortAt == accepted) begin
                reset     = 1'b0;
                readReady = 1'b0;
                @(negedge clk);
                checkResetValues("abort");
                clearModel();
                return;
            end
            if (readValid && firstValid < 0) firstValid = cycles;
            if (accPrev) check("gap_low", 32'(readValid), 0);
            if (accPrev2 && !accPrev) check("next_valid", 32'(readValid), 1);
            if (stallPrev) begin
                check("stall_valid", 32'(readValid), 1);
                check("stall_x", 32'(readX), 32'(holdX));
                check("stall_y", 32'(readY), 32'(holdY));
                check("stall_data", 32'(readData), 32'(holdD));
            end
            if (readValid) begin
                check("read_x", 32'(readX), 32'(expQ[0].x));
                check("read_y", 32'(readY), 32'(expQ[0].y));
                check("read_data", 32'(readData), 32'(expQ[0].d));
            end
            if (injectAt == accepted && !injected) begin
                injected             = 1'b1;
                writeMedianMem       = 1'b1;
                xAddressOutMedianMem = ADDR_W'(3);
                yAddressOutMedianMem = ADDR_W'(3);
                writeMedianData      = 1'b1;
            end
            readReady = randomReady ? ($urandom_range(0, 2) != 0) : 1'b1;
            accept    = readValid && readReady;
            stallPrev = readValid && !readReady;
            holdX = readX;
            holdY = readY;
            holdD = readData;
            @(negedge clk);
            cycles++;
            writeMedianMem  = 1'b0;
            writeMedianData = 1'b0;
            if (accept) begin
                p = expQ.pop_front();
                model[p.x][p.y] = 1'b0;
                accepted++;
            end
            check("frame_done", 32'(frameDone), 32'(accept && expQ.size() == 0));
            accPrev2 = accPrev;
            accPrev  = accept;
        end
        readReady = 1'b0;
        check("all_pixels_read", expQ.size(), 0);
        check("first_valid_latency", firstValid, 1);
        check("post_frame_count", 32'(activeCount), 0);
        check("post_frame_busy", 32'(busy), 0);
        check("post_frame_valid", 32'(readValid), 0);
        onesWritten = 0;
    endtask

    initial begin
        clearModel();
        repeat (3) @(negedge clk);
        checkResetValues("reset");
        reset = 1'b1;
        waitClear();
        check("idle_dropped", 32'(droppedWrite), 0);
        check("idle_addrerr", 32'(addrError), 0);

        // Frame 1: random bits, two out-of-range writes, last write shares the done cycle.
        for (int i = 0; i < DEPTH - 1; i++)
            capture(i / Y_SIZE, i % Y_SIZE, bit'($urandom_range(0, 1)), 1'b0);
        capture(X_SIZE, 0, 1'b1, 1'b0);
        check("addr_error_x", 32'(addrError), 1);
        capture(0, Y_SIZE, ~model[1][0], 1'b0);
        capture(X_SIZE - 1, Y_SIZE - 1, 1'b1, 1'b1);
        check("read_entry_busy", 32'(busy), 1);
        check("read_entry_valid", 32'(readValid), 0);
        readFrame(1'b0, -1, -1);
        check("f1_dropped", 32'(droppedWrite), 0);

        // Frame 2: single set pixel written in the frameDone cycle, backpressure, dropped write.
        check("f2_done_cycle", 32'(frameDone), 1);
        capture(5, 7, 1'b1, 1'b0);
        check("f2_capture_dropped", 32'(droppedWrite), 0);
        pulseDone();
        readFrame(1'b1, 30, -1);
        check("f2_dropped", 32'(droppedWrite), 1);
        check("f2_addrerr_sticky", 32'(addrError), 1);

        // Frame 3: random frame, reset part way through the readout.
        writeRandomFrame();
        pulseDone();
        readFrame(1'b1, -1, 50);
        reset = 1'b1;
        waitClear();

        // Frame 4: nothing written since the reset, so the readout must be all zeros.
        pulseDone();
        readFrame(1'b0, -1, -1);
        @(negedge clk);
        check("frame_done_single", 32'(frameDone), 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
